// File: rtl/wrt_ptr_sync_level.sv
// wrt_ptr_sync_level
// Read-domain write-pointer synchroniser for the async FIFO. Carries the Gray
// write pointer across a SYNC_STAGES flop chain, converts it to binary, flags
// each advance and derives fill level / empty / almost-empty against the local
// binary read pointer.
// Optional build macro: WPTR_SYNC_CHECK_EN adds a sticky protocol checker that
// drives sync_err; without it sync_err is a constant 0.
module wrt_ptr_sync_level #(
    parameter int ADDR_SIZE   = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AE_THRESH   = 2
) (
    input  logic                 rd_clk,
    input  logic                 rd_rst_n,
    input  logic [ADDR_SIZE:0]   wrt_ptr_gray,
    input  logic [ADDR_SIZE:0]   rd_ptr_bin,
    output logic [ADDR_SIZE:0]   sync_wrt_ptr_gray,
    output logic [ADDR_SIZE:0]   sync_wrt_ptr_bin,
    output logic                 wrt_adv,
    output logic [ADDR_SIZE:0]   rd_level,
    output logic                 rd_empty,
    output logic                 rd_almost_empty,
    output logic                 sync_err
);

    localparam int PW = ADDR_SIZE + 1;

    // Level of a completely full FIFO: MSB set, lower bits zero.
    localparam logic [PW-1:0] FULL_LEVEL = {1'b1, {ADDR_SIZE{1'b0}}};
    localparam logic [PW-1:0] AE_LEVEL   = PW'(AE_THRESH);

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] gray);
        logic [PW-1:0] bin;
        bin[PW-1] = gray[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

    logic [PW-1:0] sync_q [SYNC_STAGES];
    logic [PW-1:0] bin_d;
    logic [PW-1:0] bin_q;
    logic          adv_d;
    logic          adv_q;

    // Synchroniser chain: stage 0 captures the asynchronous Gray pointer.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= {PW{1'b0}};
            end
        end else begin
            sync_q[0] <= wrt_ptr_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync_wrt_ptr_gray = sync_q[SYNC_STAGES-1];

    // Next binary pointer and advance flag from the last synchroniser stage.
    always_comb begin
        bin_d = gray2bin(sync_q[SYNC_STAGES-1]);
        adv_d = 1'b0;
        if (bin_d != bin_q) begin
            adv_d = 1'b1;
        end else begin
            adv_d = 1'b0;
        end
    end

    // Binary pointer register; the advance pulse is aligned with its update.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            bin_q <= {PW{1'b0}};
            adv_q <= 1'b0;
        end else begin
            bin_q <= bin_d;
            adv_q <= adv_d;
        end
    end

    assign sync_wrt_ptr_bin = bin_q;
    assign wrt_adv          = adv_q;

    // Fill level follows the read pointer with zero latency; modular
    // subtraction absorbs pointer wrap, and level 2^ADDR_SIZE means full.
    always_comb begin
        rd_level        = bin_q - rd_ptr_bin;
        rd_empty        = 1'b0;
        rd_almost_empty = 1'b0;
        if (rd_level == {PW{1'b0}}) begin
            rd_empty = 1'b1;
        end else begin
            rd_empty = 1'b0;
        end
        if (rd_level <= AE_LEVEL) begin
            rd_almost_empty = 1'b1;
        end else begin
            rd_almost_empty = 1'b0;
        end
    end

`ifdef WPTR_SYNC_CHECK_EN

    // True when two pointer samples differ in more than one bit.
    function automatic logic multi_bit_change(input logic [PW-1:0] a,
                                              input logic [PW-1:0] b);
        logic [PW-1:0] diff;
        diff = a ^ b;
        return ((diff & (diff - PW'(1))) != {PW{1'b0}});
    endfunction

    logic [PW-1:0] prev_gray_q;
    logic          err_d;
    logic          err_q;

    // Error detection: Gray step larger than one bit, or read ran past write.
    always_comb begin
        err_d = err_q;
        if (multi_bit_change(sync_q[SYNC_STAGES-1], prev_gray_q) ||
            (rd_level > FULL_LEVEL)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Previous synchronised pointer and sticky error flag.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            prev_gray_q <= {PW{1'b0}};
            err_q       <= 1'b0;
        end else begin
            prev_gray_q <= sync_q[SYNC_STAGES-1];
            err_q       <= err_d;
        end
    end

    assign sync_err = err_q;

`else

    assign sync_err = 1'b0;

`endif

endmodule
